div_unit: RTL and testbench



---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for the DIV/DIVU instructions.
//
// A restoring shift-subtract divider that retires one quotient bit per cycle,
// MSB first. A request sampled in IDLE produces a result 33 cycles later.
// Signed operands are divided as magnitudes and the signs are applied when
// the result is written out.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   div         divide request (level); honoured only when the unit is armed
//   div_signed  1 = signed DIV, 0 = unsigned DIVU; sampled with the request
//   sweap       pipeline flush; aborts RUN/DONE and blocks a start in IDLE
//   x, y        dividend and divisor; sampled with the request
//   busy        high while in RUN or DONE
//   complete    one-cycle pulse while in DONE; s and r are valid then
//   s, r        quotient (to LO) and remainder (to HI); held until the next result
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div,
  input  logic              div_signed,
  input  logic              sweap,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              complete,
  output logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] r
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negation; wraps so that the negation of the most
  // negative value is itself.
  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Magnitude of a signed operand, returned as an unsigned value so that
  // the most negative input maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg(v) : v;
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               armed;
  logic               sign_q, sign_r;
  logic [DATA_W-1:0]  dvsr;
  logic [DATA_W-1:0]  quo;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [DATA_W-1:0]  rem;

  logic               start, abort, last_iter;
  logic [DATA_W:0]    part_rem;
  logic               ge;
  logic [DATA_W-1:0]  rem_nxt, quo_nxt;
  logic [DATA_W-1:0]  s_fin, r_fin;

  // One restoring iteration. When the trial subtraction succeeds the true
  // difference is below the divisor, so the low DATA_W bits are exact.
  always_comb begin
    part_rem  = {rem, quo[DATA_W-1]};
    ge        = part_rem >= {1'b0, dvsr};
    rem_nxt   = ge ? (part_rem[DATA_W-1:0] - dvsr) : part_rem[DATA_W-1:0];
    quo_nxt   = {quo[DATA_W-2:0], ge};
    last_iter = (cnt == CNT_W'(DATA_W - 1));
    // A zero divisor naturally yields |x| as the remainder, so the sign fix
    // on r restores x; only the quotient is forced to all ones.
    s_fin     = (dvsr == '0) ? '1 : (sign_q ? neg(quo_nxt) : quo_nxt);
    r_fin     = sign_r ? neg(rem_nxt) : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (div && !sweap && armed) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (sweap) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        abort     = sweap;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign complete = (state == DONE) && !sweap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      armed  <= 1'b1;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      s      <= '0;
      r      <= '0;
    end else begin
      state <= state_nxt;

      if (start) begin
        cnt    <= '0;
        rem    <= '0;
        dvsr   <= div_signed ? mag(y) : y;
        quo    <= div_signed ? mag(x) : x;
        sign_q <= div_signed & (x[DATA_W-1] ^ y[DATA_W-1]);
        sign_r <= div_signed & x[DATA_W-1];
      end else if (state == RUN && !sweap) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          s <= s_fin;
          r <= r_fin;
        end
      end

      // A request must be seen low in IDLE before the unit will start again,
      // so a request held across complete does not retrigger.
      if ((state == RUN && !sweap && last_iter) || abort) begin
        armed <= 1'b0;
      end else if (state == IDLE && !div) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div;
  logic        div_signed;
  logic        sweap;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        complete;
  logic [31:0] s;
  logic [31:0] r;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .div        (div),
    .div_signed (div_signed),
    .sweap      (sweap),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .complete   (complete),
    .s          (s),
    .r          (r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request in the current cycle (cycle 0), drop div and scramble
  // the operands afterwards, and follow the unit through cycle 34.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] es, input logic [31:0] er);
    int n_cmp = 0;
    int first = -1;
    logic busy_ok = 1'b1;
    div = 1'b1; div_signed = sgn; x = a; y = b;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 1) begin
        div = 1'b0; div_signed = ~sgn; x = 32'hDEADBEEF; y = 32'h00000003;
      end
      if (complete === 1'b1) begin
        n_cmp++;
        if (first < 0) first = k;
      end
      if (k <= 33 && busy !== 1'b1) busy_ok = 1'b0;
      if (k == 34 && busy !== 1'b0) busy_ok = 1'b0;
    end
    chk({tag, " pulses"}, n_cmp, 1);
    chk({tag, " latency"}, first, 33);
    chk({tag, " busy"}, {31'd0, busy_ok}, 1);
    chk({tag, " s"}, s, es);
    chk({tag, " r"}, r, er);
    tick();
  endtask

  initial begin
    int n_cmp;
    int first;

    reset = 1'b1; div = 1'b0; div_signed = 1'b0; sweap = 1'b0; x = '0; y = '0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset complete", {31'd0, complete}, 0);
    chk("reset s", s, 0);
    chk("reset r", r, 0);

    // Request issued in the very first cycle after reset drops.
    reset = 1'b0;
    run_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_op("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
    run_op("u/0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run_op("s/0", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run_op("s ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_op("u ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("u big", 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F);

    // Abort in RUN cycle 10: previous result must survive, no pulse.
    run_op("u100/7 again", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    div = 1'b1; div_signed = 1'b0; x = 32'd50; y = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) div = 1'b0;
    end
    sweap = 1'b1;
    tick();
    sweap = 1'b0;
    chk("abort busy", {31'd0, busy}, 0);
    n_cmp = 0;
    for (int k = 0; k < 40; k++) begin
      if (complete === 1'b1) n_cmp++;
      tick();
    end
    chk("abort no pulse", n_cmp, 0);
    chk("abort s held", s, 32'd14);
    chk("abort r held", r, 32'd2);

    // Flush in IDLE blocks a start in that cycle.
    div = 1'b1; sweap = 1'b1; x = 32'd9; y = 32'd4;
    tick();
    chk("idle flush busy", {31'd0, busy}, 0);
    div = 1'b0; sweap = 1'b0;
    tick();
    run_op("u9/4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    // Flush while in DONE suppresses the pulse.
    div = 1'b1; div_signed = 1'b0; x = 32'd20; y = 32'd6;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 1) div = 1'b0;
    end
    chk("done pre-flush complete", {31'd0, complete}, 1);
    sweap = 1'b1;
    #1;
    chk("done flush complete", {31'd0, complete}, 0);
    tick();
    sweap = 1'b0;
    chk("done flush busy", {31'd0, busy}, 0);
    tick();

    // Reset in the middle of RUN.
    div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) div = 1'b0;
    end
    reset = 1'b1;
    tick();
    chk("mid reset busy", {31'd0, busy}, 0);
    chk("mid reset complete", {31'd0, complete}, 0);
    chk("mid reset s", s, 0);
    chk("mid reset r", r, 0);
    reset = 1'b0;
    n_cmp = 0;
    for (int k = 0; k < 40; k++) begin
      if (complete === 1'b1) n_cmp++;
      tick();
    end
    chk("mid reset no pulse", n_cmp, 0);

    // Request held for 80 cycles produces a single result.
    div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
    n_cmp = 0; first = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (complete === 1'b1) begin
        n_cmp++;
        if (first < 0) first = k;
      end
    end
    chk("held pulses", n_cmp, 1);
    chk("held latency", first, 33);
    chk("held s", s, 32'd14);
    div = 1'b0;
    tick();
    div = 1'b1; x = 32'd9; y = 32'd4;
    n_cmp = 0; first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (complete === 1'b1) begin
        n_cmp++;
        if (first < 0) first = k;
      end
    end
    div = 1'b0;
    chk("rearm pulses", n_cmp, 1);
    chk("rearm latency", first, 33);
    chk("rearm s", s, 32'd2);
    chk("rearm r", r, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
